// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and channel-index type for the 1-to-4 buffered demux
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int STAT_W = 16;

  typedef logic [SEL_W-1:0] chan_idx_t;
endpackage

// File: rtl/demux_1to4_buffered_chan_fifo.sv
// rtl/demux_1to4_buffered_chan_fifo.sv - per-channel FIFO (chan_fifo) with registered head
// The parent gates push with not-full and pop with not-empty, so neither is re-checked here.
module chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers are power-of-two wide, so natural overflow gives the modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
endmodule

// File: rtl/demux_1to4_buffered.sv
// rtl/demux_1to4_buffered.sv - 1-to-4 demux with a FIFO per output channel
// Optional per-channel pop counters on stat_count when DEMUX_STATS_EN is defined.
module demux_1to4_buffered
  import demux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        in_data,
  input  chan_idx_t               in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready
`ifdef DEMUX_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0] stat_count
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]     cnt  [NUM_CH];
  logic [WIDTH-1:0]  head [NUM_CH];
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  // Readiness looks only at the stored count, never at out_ready.
  assign in_ready = (cnt[in_sel] != FULL);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k] = in_valid && in_ready && (in_sel == chan_idx_t'(k));
    assign pop[k]  = out_valid[k] && out_ready[k];

    chan_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[k]),
      .push_data(in_data),
      .pop      (pop[k]),
      .head_data(head[k]),
      .count    (cnt[k])
    );

    assign out_valid[k]                = (cnt[k] != '0);
    assign out_data[k*WIDTH +: WIDTH]  = head[k];
  end

`ifdef DEMUX_STATS_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
    logic [STAT_W-1:0] stat_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stat_q <= '0;
      end else if (pop[k]) begin
        stat_q <= stat_q + STAT_W'(1);
      end
    end
    assign stat_count[k*STAT_W +: STAT_W] = stat_q;
  end
`endif

  a_producer_hold: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_data) && $stable(in_sel)));
endmodule

// File: tb/tb_demux_1to4_buffered.sv
// tb/tb_demux_1to4_buffered.sv - directed self-checking bench for demux_1to4_buffered
module tb_demux_1to4_buffered;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = 4'hF;
`ifdef DEMUX_STATS_EN
  logic [63:0]  stat_count;
`endif

  int errors = 0;
  int checks = 0;

  demux_1to4_buffered #(.WIDTH(32), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DEMUX_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ch_data(input int k);
    return out_data[k*32 +: 32];
  endfunction

  task automatic push_word(input logic [1:0] sel, input logic [31:0] d);
    in_sel = sel; in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
    checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    @(posedge clk); #1; rst = 1'b0;
    out_ready = 4'b0000;
    push_word(2'd1, 32'h0000_0111);
    push_word(2'd1, 32'h0000_0222);
    checks++; if (out_valid !== 4'b0010) begin errors++; $display("FAIL queued_valid got=%b exp=0010", out_valid); end
    #3 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL midrst_valid got=%b exp=0000", out_valid); end
    checks++; if (out_data !== 128'd0) begin errors++; $display("FAIL midrst_data got=%h exp=0", out_data); end
    @(posedge clk); #1; rst = 1'b0;
    out_ready = 4'hF;
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0]; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready sel=%0d got=%b exp=1", s, in_ready); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_routing;
    logic [31:0] words [4];
    words[0] = 32'hA0; words[1] = 32'hB1; words[2] = 32'hC2; words[3] = 32'hD3;
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      in_sel = k[1:0]; in_data = words[k]; in_valid = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready ch=%0d got=%b exp=1", k, in_ready); end
      @(posedge clk); #1; in_valid = 1'b0;
      checks++; if (out_valid !== (4'b0001 << k)) begin errors++; $display("FAIL route_valid ch=%0d got=%b exp=%b", k, out_valid, 4'b0001 << k); end
      checks++; if (ch_data(k) !== words[k]) begin errors++; $display("FAIL route_data ch=%0d got=%h exp=%h", k, ch_data(k), words[k]); end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL route_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_full;
    out_ready = 4'b0111;
    in_sel = 2'd3; in_data = 32'h31; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_first got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_data = 32'h32;
    @(posedge clk); #1;
    in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_third got=%b exp=0", in_ready); end
    checks++; if (out_valid[3] !== 1'b1 || ch_data(3) !== 32'h31) begin errors++; $display("FAIL full_head got=%b/%h exp=1/31", out_valid[3], ch_data(3)); end
    in_sel = 2'd0; in_data = 32'h0A; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL other_ch_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    checks++; if (out_valid[0] !== 1'b1 || ch_data(0) !== 32'h0A) begin errors++; $display("FAIL other_ch_data got=%b/%h exp=1/0a", out_valid[0], ch_data(0)); end
    in_sel = 2'd3; in_data = 32'h33; in_valid = 1'b1; out_ready = 4'hF; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_while_pop got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got=%b exp=1", in_ready); end
    checks++; if (ch_data(3) !== 32'h32) begin errors++; $display("FAIL order_second got=%h exp=32", ch_data(3)); end
    @(posedge clk); #1; in_valid = 1'b0;
    checks++; if (out_valid[3] !== 1'b1 || ch_data(3) !== 32'h33) begin errors++; $display("FAIL order_third got=%b/%h exp=1/33", out_valid[3], ch_data(3)); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL full_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_simul;
    out_ready = 4'b1011;
    push_word(2'd2, 32'h11);
    checks++; if (out_valid[2] !== 1'b1 || ch_data(2) !== 32'h11) begin errors++; $display("FAIL simul_pre got=%b/%h exp=1/11", out_valid[2], ch_data(2)); end
    in_sel = 2'd2; in_data = 32'h55; in_valid = 1'b1; out_ready = 4'hF;
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 4'b1011;
    checks++; if (out_valid[2] !== 1'b1 || ch_data(2) !== 32'h55) begin errors++; $display("FAIL simul_head got=%b/%h exp=1/55", out_valid[2], ch_data(2)); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid[2] !== 1'b1) begin errors++; $display("FAIL simul_count1 ready=%b valid=%b exp=1/1", in_ready, out_valid[2]); end
    out_ready = 4'hF;
    @(posedge clk); #1;
    checks++; if (out_valid !== 4'b0000) begin errors++; $display("FAIL simul_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_wrap;
    logic [31:0] rx [$];
    int s = 0;
    int cyc = 0;
    logic acc, pv;
    logic [31:0] pd;
    while (rx.size() < 10 && cyc < 200) begin
      out_ready = {3'b111, (cyc > 100) ? 1'b1 : 1'($urandom_range(0, 1))};
      in_sel = 2'd0; in_valid = (s < 10); in_data = 32'h100 + s;
      #2;
      acc = in_valid && in_ready;
      pv  = out_valid[0] && out_ready[0];
      pd  = ch_data(0);
      @(posedge clk); #1;
      if (acc) s++;
      if (pv) rx.push_back(pd);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 4'hF;
    checks++; if (rx.size() !== 10) begin errors++; $display("FAIL wrap_count got=%0d exp=10", rx.size()); end
    for (int i = 0; i < rx.size(); i++) begin
      checks++; if (rx[i] !== 32'h100 + i) begin errors++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, rx[i], 32'h100 + i); end
    end
    @(posedge clk); #1;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%b exp=0", out_valid[0]); end
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats;
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 4'hF;
    for (int i = 0; i < 5; i++) push_word(2'd1, 32'h700 + i);
    @(posedge clk); #1;
    checks++; if (stat_count[31:16] !== 16'd5) begin errors++; $display("FAIL stat_ch1 got=%0d exp=5", stat_count[31:16]); end
    checks++; if ({stat_count[63:32], stat_count[15:0]} !== 48'd0) begin errors++; $display("FAIL stat_others got=%h exp=0", {stat_count[63:32], stat_count[15:0]}); end
    in_sel = 2'd1; in_data = 32'h9; in_valid = 1'b1;
    repeat (65532) @(posedge clk);
    #1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (stat_count[31:16] !== 16'd1) begin errors++; $display("FAIL stat_wrap got=%0d exp=1", stat_count[31:16]); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset();
    test_routing();
    test_full();
    test_simul();
    test_wrap();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux_1to4_buffered.md
Name: demux_1to4_buffered

Overview:
- Sequential 1-to-4 demultiplexer, the distributing counterpart of the 4-to-1 source-select mux in the datapath.
- Accepts one WIDTH-bit word per cycle on a valid/ready input and steers it to one of four output channels chosen by in_sel.
- Each channel has its own small FIFO, so a stalled consumer only back-pressures traffic addressed to that channel.
- Sits between a single producer (e.g. result/write-back path) and four independent consumers.

Parameters:
- WIDTH, 32, data width of every channel.
- DEPTH, 2, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word to deliver.
- in_sel  input  2  destination channel: 0..3 map to channel 0..3 exactly.
- in_valid  input  1  producer offers in_data/in_sel.
- in_ready  output  1  selected channel can accept this cycle.
- out_data  output  4*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  4  bit k set when channel k holds data.
- out_ready  input  4  bit k set when consumer k takes its head word.

Behaviour:
- Reset (async assert, sync-released use): all FIFO counts and pointers 0, storage 0, out_valid=4'b0000, out_data=0. Asserting rst mid-operation discards all buffered words immediately.
- Push: in_valid && in_ready at a rising edge writes in_data into FIFO[in_sel] at its write pointer. The write pointer increments and the count increments.
- Pop: out_valid[k] && out_ready[k] at a rising edge advances read pointer k and decrements count k.
- out_data[k] is the FIFO k head, driven from registered storage. out_valid[k] = (count_k != 0). There is no combinational path from in_* to out_*.
- in_ready = (count[in_sel] != DEPTH). It is combinational on in_sel only. There is no combinational path from out_ready to in_ready, so a full channel stays not-ready even while it is being popped that cycle.
- Latency: a word pushed at edge N into an empty channel is visible at out_* after edge N (out_valid high in cycle N+1).
- Simultaneous push and pop on the same non-full channel: count unchanged, both pointers advance, and the word order stays correct.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits and ranges 0..DEPTH.
- Order is preserved within each channel. No ordering is guaranteed across channels.
- in_valid low: in_sel is don't-care and no state changes on the input side.
- Pops on different channels in the same cycle are all independent and all allowed.
- Producer rule (checked by assertion): once in_valid is high with !in_ready, in_data/in_sel stay stable until accepted.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined: adds output port stat_count (4*16 bits). Field k counts words popped from channel k, wraps at 2^16, and resets to 0 with rst.
- Undefined: the port and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Package demux_pkg:
  - NUM_CH=4, SEL_W=2, STAT_W=16.
  - Channel-index typedef (SEL_W bits).
- Sub-module chan_fifo (WIDTH, DEPTH), instantiated four times:
  - Ports: clk, rst, push, push_data, pop, head_data, count.
  - Top level holds only the decode of in_sel into four push strobes, in_ready selection and the optional stats counters.

Test Plan:
- Reset: assert rst mid-stream with 2 words queued in channel 1 -> out_valid=0000, out_data=0 immediately. After release, in_ready=1 for all in_sel.
- Routing: push 0xA0, 0xB1, 0xC2, 0xD3 with in_sel=0,1,2,3, all out_ready=1 -> each word appears on only its own channel one cycle after acceptance. Channel 2 shows 0xC2.
- Full/back-pressure: out_ready[3]=0, push 3 words to ch3 -> first 2 accepted, in_ready=0 on the third. Pushes to ch0 are still accepted. Raising out_ready[3] releases the words in order and in_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop: ch2 holding 1 word, push 0x55 while popping -> count stays 1 and the head becomes 0x55.
- Wrap-around: 10 back-to-back words through ch0 with random out_ready -> all 10 received in order with no loss or duplication.
- Stats (DEMUX_STATS_EN): pop 5 words from ch1 -> stat_count field 1 = 5 and the other fields = 0. Pop 65537 words -> field reads 1.
